// File: rtl/tim_bank_pkg.sv
// Shared constants, register map and address decode helper for the
// multi-channel timer bank.
package tim_bank_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] TIM_BASE_ADDR = 32'h0000_2000;

    typedef enum logic [1:0] {
        TIM_CONF   = 2'd0,
        TIM_RELOAD = 2'd1,
        TIM_CNT    = 2'd2,
        TIM_STATUS = 2'd3
    } tim_reg_e;

    localparam int TIM_EN_BIT  = 0;
    localparam int TIM_IE_BIT  = 1;
    localparam int TIM_OS_BIT  = 2;
    localparam int TIM_PSC_LSB = 8;

    typedef struct packed {
        logic     valid;
        logic [2:0] ch;
        tim_reg_e rsel;
    } tim_dec_t;

    // The channel field is 3 bits wide because at most 8 channels exist.
    function automatic tim_dec_t tim_decode(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] base,
                                            input int unsigned ch_num);
        logic [ADDR_W-1:0] off;
        tim_dec_t          dec;
        off       = addr - base;
        dec.valid = (off < ADDR_W'(ch_num * 16)) && (off[1:0] == 2'b00);
        dec.ch    = off[6:4];
        dec.rsel  = tim_reg_e'(off[3:2]);
        return dec;
    endfunction

endpackage

// File: rtl/tim_channel.sv
// One timer channel: prescaler, up-counter with auto-reload, CONF fields
// and the W1C overflow flag.
module tim_channel
    import tim_bank_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int PSC_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              conf_we,
    input  logic              reload_we,
    input  logic              cnt_we,
    input  logic              status_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] conf_o,
    output logic [DATA_W-1:0] reload_o,
    output logic [DATA_W-1:0] cnt_o,
    output logic [DATA_W-1:0] status_o,
    output logic              irq_o
);

    logic                 en_q, en_d, ie_q, ie_d, os_q, os_d, ovf_q, ovf_d;
    logic [PSC_WIDTH-1:0] psc_q, psc_d, psc_cnt_q, psc_cnt_d;
    logic [CNT_WIDTH-1:0] reload_q, reload_d, cnt_q, cnt_d;
    logic                 tick, ovf_set;
    logic                 unused_wdata;

    assign unused_wdata = ^wdata;

    always_comb begin
        tick      = en_q && (psc_cnt_q == psc_q);
        // A software CNT write overrides the tick entirely, overflow included.
        ovf_set   = tick && !cnt_we && (cnt_q == reload_q);
        psc_cnt_d = (!en_q || tick) ? '0 : psc_cnt_q + PSC_WIDTH'(1);

        en_d  = en_q;
        ie_d  = ie_q;
        os_d  = os_q;
        psc_d = psc_q;
        if (conf_we) begin
            en_d  = wdata[TIM_EN_BIT];
            ie_d  = wdata[TIM_IE_BIT];
            os_d  = wdata[TIM_OS_BIT];
            psc_d = wdata[TIM_PSC_LSB +: PSC_WIDTH];
        end else if (ovf_set && os_q) begin
            en_d = 1'b0;
        end

        reload_d = reload_we ? wdata[CNT_WIDTH-1:0] : reload_q;

        cnt_d = cnt_q;
        if (cnt_we)       cnt_d = wdata[CNT_WIDTH-1:0];
        else if (ovf_set) cnt_d = '0;
        else if (tick)    cnt_d = cnt_q + CNT_WIDTH'(1);

        ovf_d = ovf_q;
        if (ovf_set)                  ovf_d = 1'b1;
        else if (status_we && wdata[0]) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            os_q      <= 1'b0;
            ovf_q     <= 1'b0;
            psc_q     <= '0;
            psc_cnt_q <= '0;
            reload_q  <= '0;
            cnt_q     <= '0;
        end else begin
            en_q      <= en_d;
            ie_q      <= ie_d;
            os_q      <= os_d;
            ovf_q     <= ovf_d;
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
            reload_q  <= reload_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        conf_o                            = '0;
        conf_o[TIM_EN_BIT]                = en_q;
        conf_o[TIM_IE_BIT]                = ie_q;
        conf_o[TIM_OS_BIT]                = os_q;
        conf_o[TIM_PSC_LSB +: PSC_WIDTH]  = psc_q;
        reload_o                          = DATA_W'(reload_q);
        cnt_o                             = DATA_W'(cnt_q);
        status_o                          = DATA_W'(ovf_q);
        irq_o                             = ovf_q & ie_q;
    end

endmodule

// File: rtl/tim_bank.sv
// Multi-channel timer bank: address decode, registered read mux and the
// merged, registered interrupt request.
module tim_bank
    import tim_bank_pkg::*;
#(
    parameter int                CH_NUM    = 4,
    parameter int                CNT_WIDTH = 16,
    parameter int                PSC_WIDTH = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = TIM_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] tim_r_addr_i,
    input  logic [ADDR_W-1:0] tim_w_addr_i,
    input  logic [DATA_W-1:0] tim_data_i,
    input  logic              tim_r_enable_i,
    input  logic              tim_w_enable_i,
    output logic [DATA_W-1:0] tim_data_o,
    output logic              tim_irq_o
);

    tim_dec_t          r_dec, w_dec;
    logic [CH_NUM-1:0] conf_we, reload_we, cnt_we, status_we, ch_irq;
    logic [DATA_W-1:0] conf_rd [CH_NUM];
    logic [DATA_W-1:0] reload_rd [CH_NUM];
    logic [DATA_W-1:0] cnt_rd [CH_NUM];
    logic [DATA_W-1:0] status_rd [CH_NUM];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] data_q, data_d;
    logic              irq_q, irq_d;

    always_comb begin
        r_dec = tim_decode(tim_r_addr_i, BASE_ADDR, CH_NUM);
        w_dec = tim_decode(tim_w_addr_i, BASE_ADDR, CH_NUM);
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic sel;
        assign sel          = tim_w_enable_i && w_dec.valid && (w_dec.ch == 3'(g));
        assign conf_we[g]   = sel && (w_dec.rsel == TIM_CONF);
        assign reload_we[g] = sel && (w_dec.rsel == TIM_RELOAD);
        assign cnt_we[g]    = sel && (w_dec.rsel == TIM_CNT);
        assign status_we[g] = sel && (w_dec.rsel == TIM_STATUS);

        tim_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .PSC_WIDTH (PSC_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .conf_we   (conf_we[g]),
            .reload_we (reload_we[g]),
            .cnt_we    (cnt_we[g]),
            .status_we (status_we[g]),
            .wdata     (tim_data_i),
            .conf_o    (conf_rd[g]),
            .reload_o  (reload_rd[g]),
            .cnt_o     (cnt_rd[g]),
            .status_o  (status_rd[g]),
            .irq_o     (ch_irq[g])
        );
    end

    // Read mux sees the channel registers before this edge's updates.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (r_dec.ch == 3'(i)) begin
                case (r_dec.rsel)
                    TIM_CONF:   rd_word = conf_rd[i];
                    TIM_RELOAD: rd_word = reload_rd[i];
                    TIM_CNT:    rd_word = cnt_rd[i];
                    default:    rd_word = status_rd[i];
                endcase
            end
        end
        data_d = data_q;
        if (tim_r_enable_i) data_d = r_dec.valid ? rd_word : '0;
        irq_d = |ch_irq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            irq_q  <= irq_d;
        end
    end

    assign tim_data_o = data_q;
    assign tim_irq_o  = irq_q;

endmodule

// File: tb/tb_tim_bank.sv
// Directed self-checking bench for tim_bank: periodic, one-shot, collision,
// multi-channel, invalid-address and reset scenarios.
module tb_tim_bank;
    import tim_bank_pkg::*;

    localparam int          CH_NUM = 4;
    localparam logic [31:0] BASE   = 32'h0000_2000;

    logic        clk;
    logic        rst_n;
    logic [31:0] tim_r_addr_i;
    logic [31:0] tim_w_addr_i;
    logic [31:0] tim_data_i;
    logic        tim_r_enable_i;
    logic        tim_w_enable_i;
    logic [31:0] tim_data_o;
    logic        tim_irq_o;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] rd;

    tim_bank #(
        .CH_NUM    (CH_NUM),
        .CNT_WIDTH (16),
        .PSC_WIDTH (8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tim_r_addr_i   (tim_r_addr_i),
        .tim_w_addr_i   (tim_w_addr_i),
        .tim_data_i     (tim_data_i),
        .tim_r_enable_i (tim_r_enable_i),
        .tim_w_enable_i (tim_w_enable_i),
        .tim_data_o     (tim_data_o),
        .tim_irq_o      (tim_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] reg_addr(input int ch, input int r);
        return BASE + 32'(ch * 16 + r * 4);
    endfunction

    // Bus tasks start and end on a falling edge; each takes one cycle.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        tim_w_addr_i   = a;
        tim_data_i     = d;
        tim_w_enable_i = 1'b1;
        @(negedge clk);
        tim_w_enable_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        tim_r_addr_i   = a;
        tim_r_enable_i = 1'b1;
        @(negedge clk);
        tim_r_enable_i = 1'b0;
        d = tim_data_o;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        tim_r_addr_i = '0; tim_w_addr_i = '0; tim_data_i = '0;
        tim_r_enable_i = 1'b0; tim_w_enable_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tim_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected %h", tim_data_o, 32'h0); end
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", tim_irq_o); end
        idle(2);
        rst_n = 1'b1;
        bus_rd(reg_addr(0, 0), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_conf0: got %h expected %h", rd, 32'h0); end
        bus_rd(reg_addr(3, 2), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_cnt3: got %h expected %h", rd, 32'h0); end
        bus_rd(reg_addr(2, 3), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status2: got %h expected %h", rd, 32'h0); end
    endtask

    // Ch0 PSC=3 RELOAD=4: enable lands at edge E0, OVF at E20, E40, ...
    task automatic test_periodic();
        bus_wr(reg_addr(0, 1), 32'd4);
        bus_wr(reg_addr(0, 0), 32'h0000_0303);
        idle(18);
        bus_rd(reg_addr(0, 3), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL per_ovf_e18: got %h expected %h", rd, 32'h0); end
        bus_rd(reg_addr(0, 3), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL per_ovf_e19: got %h expected %h", rd, 32'h0); end
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL per_irq_e20: got %b expected 0", tim_irq_o); end
        bus_rd(reg_addr(0, 3), rd);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL per_ovf_e20: got %h expected %h", rd, 32'h1); end
        n_cmp++; if (tim_irq_o !== 1'b1) begin n_fail++; $display("FAIL per_irq_e21: got %b expected 1", tim_irq_o); end
        bus_rd(reg_addr(0, 2), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL per_cnt_wrap: got %h expected %h", rd, 32'h0); end
        bus_wr(reg_addr(0, 3), 32'h1);
        n_cmp++; if (tim_irq_o !== 1'b1) begin n_fail++; $display("FAIL per_irq_lag: got %b expected 1", tim_irq_o); end
        bus_rd(reg_addr(0, 3), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL per_w1c: got %h expected %h", rd, 32'h0); end
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL per_irq_clear: got %b expected 0", tim_irq_o); end
        idle(14);
        bus_rd(reg_addr(0, 3), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL per_ovf_e38: got %h expected %h", rd, 32'h0); end
        bus_rd(reg_addr(0, 3), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL per_ovf_e39: got %h expected %h", rd, 32'h0); end
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL per_irq_e40: got %b expected 0", tim_irq_o); end
        bus_rd(reg_addr(0, 3), rd);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL per_ovf_e40: got %h expected %h", rd, 32'h1); end
        n_cmp++; if (tim_irq_o !== 1'b1) begin n_fail++; $display("FAIL per_irq_e41: got %b expected 1", tim_irq_o); end
        bus_wr(reg_addr(0, 0), 32'h0);
        bus_wr(reg_addr(0, 3), 32'h1);
        idle(1);
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL per_irq_off: got %b expected 0", tim_irq_o); end
    endtask

    // Ch1 one-shot, PSC=0, RELOAD=2: ticks at E1..E3, overflow and stop at E3.
    task automatic test_one_shot();
        bus_wr(reg_addr(1, 1), 32'd2);
        bus_wr(reg_addr(1, 0), 32'h5);
        idle(6);
        bus_rd(reg_addr(1, 0), rd);
        n_cmp++; if (rd !== 32'h4) begin n_fail++; $display("FAIL os_conf: got %h expected %h", rd, 32'h4); end
        bus_rd(reg_addr(1, 2), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL os_cnt: got %h expected %h", rd, 32'h0); end
        bus_rd(reg_addr(1, 3), rd);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL os_ovf: got %h expected %h", rd, 32'h1); end
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL os_irq_masked: got %b expected 0", tim_irq_o); end
        bus_wr(reg_addr(1, 3), 32'h1);
        idle(5);
        bus_rd(reg_addr(1, 3), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL os_single: got %h expected %h", rd, 32'h0); end
        bus_rd(reg_addr(1, 2), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL os_cnt_stays: got %h expected %h", rd, 32'h0); end
        bus_wr(reg_addr(1, 0), 32'h0);
    endtask

    task automatic test_collisions();
        // CNT write of 7 in a tick cycle (cnt would have gone 3 -> 4).
        bus_wr(reg_addr(2, 1), 32'hFF);
        bus_wr(reg_addr(2, 0), 32'h1);
        idle(3);
        bus_wr(reg_addr(2, 2), 32'h7);
        bus_rd(reg_addr(2, 2), rd);
        n_cmp++; if (rd !== 32'h7) begin n_fail++; $display("FAIL col_cnt_write: got %h expected %h", rd, 32'h7); end
        bus_rd(reg_addr(2, 2), rd);
        n_cmp++; if (rd !== 32'h8) begin n_fail++; $display("FAIL col_cnt_resume: got %h expected %h", rd, 32'h8); end
        // RELOAD=0 sets OVF on every tick, so each W1C collides with a set.
        bus_wr(reg_addr(2, 0), 32'h0);
        bus_wr(reg_addr(2, 1), 32'h0);
        bus_wr(reg_addr(2, 2), 32'h0);
        bus_wr(reg_addr(2, 0), 32'h1);
        idle(2);
        bus_wr(reg_addr(2, 3), 32'h1);
        bus_rd(reg_addr(2, 3), rd);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL col_set_wins: got %h expected %h", rd, 32'h1); end
        bus_wr(reg_addr(2, 0), 32'h0);
        bus_wr(reg_addr(2, 3), 32'h0);
        bus_rd(reg_addr(2, 3), rd);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL col_w0_noeffect: got %h expected %h", rd, 32'h1); end
        bus_wr(reg_addr(2, 3), 32'h1);
        bus_rd(reg_addr(2, 3), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL col_w1c_idle: got %h expected %h", rd, 32'h0); end
        // Ch3 one-shot, RELOAD=0: CONF rewrite at E1 beats the one-shot EN clear.
        bus_wr(reg_addr(3, 1), 32'h0);
        bus_wr(reg_addr(3, 0), 32'h5);
        bus_wr(reg_addr(3, 0), 32'h5);
        bus_rd(reg_addr(3, 0), rd);
        n_cmp++; if (rd !== 32'h5) begin n_fail++; $display("FAIL col_conf_wins: got %h expected %h", rd, 32'h5); end
        bus_rd(reg_addr(3, 0), rd);
        n_cmp++; if (rd !== 32'h4) begin n_fail++; $display("FAIL col_os_clear: got %h expected %h", rd, 32'h4); end
        bus_wr(reg_addr(3, 0), 32'h0);
        bus_wr(reg_addr(3, 3), 32'h1);
    endtask

    // Enables land at A..A+3; after k ticks CNT = k mod (RELOAD+1).
    task automatic test_multi_channel();
        do_reset();
        bus_wr(reg_addr(0, 1), 32'd3);
        bus_wr(reg_addr(1, 1), 32'd5);
        bus_wr(reg_addr(2, 1), 32'd7);
        bus_wr(reg_addr(3, 1), 32'd11);
        bus_wr(reg_addr(0, 0), 32'h1);
        bus_wr(reg_addr(1, 0), 32'h3);
        bus_wr(reg_addr(2, 0), 32'h1);
        bus_wr(reg_addr(3, 0), 32'h3);
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL mc_irq_a3: got %b expected 0", tim_irq_o); end
        idle(3);
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL mc_irq_ie_gate: got %b expected 0", tim_irq_o); end
        idle(2);
        n_cmp++; if (tim_irq_o !== 1'b1) begin n_fail++; $display("FAIL mc_irq_ch1: got %b expected 1", tim_irq_o); end
        idle(12);
        bus_rd(reg_addr(0, 2), rd);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL mc_cnt0: got %h expected %h", rd, 32'd0); end
        bus_rd(reg_addr(1, 2), rd);
        n_cmp++; if (rd !== 32'd2) begin n_fail++; $display("FAIL mc_cnt1: got %h expected %h", rd, 32'd2); end
        bus_rd(reg_addr(2, 2), rd);
        n_cmp++; if (rd !== 32'd4) begin n_fail++; $display("FAIL mc_cnt2: got %h expected %h", rd, 32'd4); end
        bus_rd(reg_addr(3, 2), rd);
        n_cmp++; if (rd !== 32'd8) begin n_fail++; $display("FAIL mc_cnt3: got %h expected %h", rd, 32'd8); end
        bus_rd(reg_addr(0, 3), rd);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL mc_ovf0: got %h expected %h", rd, 32'h1); end
        bus_wr(reg_addr(1, 0), 32'h1);
        bus_wr(reg_addr(3, 0), 32'h1);
        n_cmp++; if (tim_irq_o !== 1'b1) begin n_fail++; $display("FAIL mc_irq_ch3_left: got %b expected 1", tim_irq_o); end
        idle(1);
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL mc_irq_ie_off: got %b expected 0", tim_irq_o); end
        bus_wr(reg_addr(0, 0), 32'h3);
        idle(1);
        n_cmp++; if (tim_irq_o !== 1'b1) begin n_fail++; $display("FAIL mc_irq_ch0_ie: got %b expected 1", tim_irq_o); end
    endtask

    task automatic test_invalid_addr();
        bus_rd(reg_addr(0, 1), rd);
        n_cmp++; if (rd !== 32'd3) begin n_fail++; $display("FAIL inv_pre_read: got %h expected %h", rd, 32'd3); end
        idle(2);
        n_cmp++; if (tim_data_o !== 32'd3) begin n_fail++; $display("FAIL inv_hold: got %h expected %h", tim_data_o, 32'd3); end
        bus_rd(BASE + 32'h40, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL inv_rd_unmapped: got %h expected %h", rd, 32'h0); end
        bus_rd(reg_addr(0, 1), rd);
        bus_rd(BASE + 32'h5, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL inv_rd_misaligned: got %h expected %h", rd, 32'h0); end
        bus_rd(reg_addr(0, 1), rd);
        bus_rd(BASE - 32'h4, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL inv_rd_below: got %h expected %h", rd, 32'h0); end
        bus_wr(BASE + 32'h40, 32'h55);
        bus_wr(BASE + 32'h44, 32'h99);
        bus_wr(BASE + 32'h6, 32'hAA);
        bus_rd(reg_addr(0, 1), rd);
        n_cmp++; if (rd !== 32'd3) begin n_fail++; $display("FAIL inv_wr_reload0: got %h expected %h", rd, 32'd3); end
        bus_rd(reg_addr(0, 0), rd);
        n_cmp++; if (rd !== 32'h3) begin n_fail++; $display("FAIL inv_wr_conf0: got %h expected %h", rd, 32'h3); end
    endtask

    task automatic test_reset_mid_count();
        n_cmp++; if (tim_irq_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_irq: got %b expected 1", tim_irq_o); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tim_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h expected %h", tim_data_o, 32'h0); end
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq: got %b expected 0", tim_irq_o); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(reg_addr(0, 0), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_conf0: got %h expected %h", rd, 32'h0); end
        bus_rd(reg_addr(3, 3), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status3: got %h expected %h", rd, 32'h0); end
        idle(3);
        bus_rd(reg_addr(2, 2), rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_cnt2: got %h expected %h", rd, 32'h0); end
        n_cmp++; if (tim_irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq_after: got %b expected 0", tim_irq_o); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_one_shot();
        test_collisions();
        test_multi_channel();
        test_invalid_addr();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tim_bank.md
# tim_bank

Parametrised multi-channel timer peripheral, successor to the single-channel timer on the peripheral bus. It has CH_NUM independent channels. Each channel has its own prescaler, up-counter, auto-reload value, one-shot/periodic mode and W1C overflow flag. The per-channel interrupts are merged into one registered request for the core's interrupt controller. It sits on the same memory-mapped read/write port as the other peripherals and uses one-cycle registered reads.

## Interface
- CH_NUM, 4: number of channels (1..8).
- CNT_WIDTH, 16: counter and reload width (1..32).
- PSC_WIDTH, 8: prescaler width (1..16).
- BASE_ADDR, `tim_base_addr`: byte address of channel 0, offset 0.
- clk  in  1  the single clock; all logic is on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- tim_r_addr_i  in  `mem_addr_bus`  read byte address.
- tim_w_addr_i  in  `mem_addr_bus`  write byte address.
- tim_data_i  in  `data_bus`  write data.
- tim_r_enable_i  in  1  read strobe.
- tim_w_enable_i  in  1  write strobe.
- tim_data_o  out  `data_bus`  read data, registered.
- tim_irq_o  out  1  merged interrupt request, registered, level.

## Operation
- Address decode:
  - off = addr − BASE_ADDR.
  - The access is valid when off < CH_NUM·16 and off[1:0] = 0.
  - Channel = off[…:4]; register = off[3:2].
  - Register map: 0 CONF, 1 RELOAD, 2 CNT, 3 STATUS.
- CONF (read/write):
  - bit0 EN: channel enable.
  - bit1 IE: interrupt enable.
  - bit2 OS: one-shot mode.
  - [8+PSC_WIDTH-1:8] PSC: prescaler value.
  - All other bits read 0.
- RELOAD (read/write): [CNT_WIDTH-1:0]; upper bits read 0.
- CNT (read/write): current counter value; a software write loads the counter.
- STATUS: bit0 OVF. Writing 1 clears the flag; writing 0 has no effect. Other bits read 0.
- Prescaler, per channel:
  - psc_cnt counts 0..PSC while EN=1.
  - When psc_cnt = PSC: tick=1 for one cycle and psc_cnt returns to 0.
  - Effective division is PSC+1; PSC=0 gives a tick every cycle.
  - While EN=0, psc_cnt is held at 0.
  - A CONF write that changes EN from 0 to 1 clears psc_cnt.
- Counter, on tick:
  - If CNT = RELOAD: CNT←0 and OVF←1. If OS=1, EN←0 in the same cycle.
  - Otherwise CNT←CNT+1, wrapping modulo 2^CNT_WIDTH.
  - RELOAD=0 produces an overflow on every tick.
- Simultaneous events:
  - A software CNT write takes priority over a tick in the same cycle.
  - A hardware OVF set takes priority over a W1C clear in the same cycle.
  - A software CONF write takes priority over the one-shot EN clear.
- Interrupt: tim_irq_o ← OR over channels of (OVF & IE).
- Reads:
  - Valid address: tim_data_o ← selected register, using pre-update values for that cycle.
  - Invalid address: tim_data_o ← 0.
  - No read strobe: tim_data_o holds its value.
  - Reads have no side effects.
- Reads and writes may target any addresses in the same cycle, independently.
- Writes to invalid addresses are ignored.

## Timing
- Reset (asynchronous, rst_n=0) drives every register, psc_cnt, flag and output to 0: tim_data_o=0, tim_irq_o=0.
- Read latency: 1 cycle (strobe in cycle N, data valid after edge N).
- Register writes take effect at the edge after the strobe.
- Overflow timing:
  - The OVF flag is set at the edge where the tick meets CNT=RELOAD.
  - tim_irq_o rises one edge later.
  - tim_irq_o falls one edge after the W1C clear or after the IE clear.
- Overflow period in periodic mode: (RELOAD+1)·(PSC+1) cycles.
- Reset asserted mid-count returns the block to its reset state immediately; no partial state survives.

## Structure
- Shared constants go in define.v:
  - `tim_base_addr`.
  - Register offsets `tim_conf_off`, `tim_reload_off`, `tim_cnt_off`, `tim_status_off`.
  - CONF bit positions `tim_en_bit`, `tim_ie_bit`, `tim_os_bit`, `tim_psc_lsb`.
- Sub-module tim_channel (parameters CNT_WIDTH, PSC_WIDTH) holds the prescaler, counter, reload, CONF and OVF of one channel.
  - Inputs: per-register write strobes and data.
  - Outputs: register values and irq.
  - tim_bank instantiates CH_NUM copies and contains only the address decode, the read mux and the irq OR.

## Test plan
- Reset while counting → all reads return 0 and tim_irq_o=0 immediately.
- Ch0: PSC=3, RELOAD=4, EN=1, IE=1 → OVF set 20 cycles after enable and every 20 cycles after; tim_irq_o follows one cycle later; W1C STATUS=1 clears the irq.
- Ch1: OS=1, PSC=0, RELOAD=2 → exactly one OVF, then EN reads 0 and CNT stays 0.
- Tick in the same cycle as a CNT write of 0x7 → CNT reads 0x7. OVF set in the same cycle as a W1C → OVF reads 1.
- All channels at different RELOAD values (3, 5, 7, 11) with PSC=0 → each OVF period matches RELOAD+1; irq is the OR of the enabled flags.
- Read of an unmapped offset (channel CH_NUM) or a misaligned address → 0 after 1 cycle; writes there change no register.
